// File: rtl/sipo_4bit_shift_reg_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH serial bits into a word and strobes p_valid once per word.
// Optional macro PARITY_CHECK_EN appends an even-parity bit to each frame and reports mismatches on parity_err.
module sipo_4bit_shift_reg_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_in,
  input  logic                         s_en,
  input  logic                         clr,
  output logic [WIDTH-1:0]             p_out,
  output logic                         p_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] p_out_next;
  logic [CW-1:0]    cnt_next;
  logic             p_valid_next;
  logic             last_bit;

  // The shift direction decides which end of the word the first bit lands in.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr[WIDTH-2:0], s_in};
    end else begin : g_lsb_first
      assign sr_shift = {s_in, sr[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (bit_cnt == LAST_IDX);

  always_comb begin
    sr_next      = sr;
    cnt_next     = bit_cnt;
    p_out_next   = p_out;
    p_valid_next = 1'b0;
    if (clr) begin
      sr_next  = '0;
      cnt_next = '0;
    end else if (s_en) begin
      if (last_bit) begin
        sr_next      = '0;
        cnt_next     = '0;
        p_valid_next = 1'b1;
`ifdef PARITY_CHECK_EN
        // The final bit is the parity bit, so the data word is already complete in sr.
        p_out_next   = sr;
`else
        p_out_next   = sr_shift;
`endif
      end else begin
        sr_next  = sr_shift;
        cnt_next = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      p_out   <= '0;
      p_valid <= 1'b0;
    end else begin
      sr      <= sr_next;
      bit_cnt <= cnt_next;
      p_out   <= p_out_next;
      p_valid <= p_valid_next;
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_err_next;

  // Even parity: data bits plus parity bit must XOR to zero.
  always_comb begin
    parity_err_next = 1'b0;
    if (!clr && s_en && last_bit) begin
      parity_err_next = ^{sr, s_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_4bit_shift_reg_rx.sv
// Self-checking bench for sipo_4bit_shift_reg_rx: an MSB-first and an LSB-first instance share the same serial stream.
// Completed words are checked against per-instance scoreboard queues; hand sequences cover gaps, clr and async reset.
module tb_sipo_4bit_shift_reg_rx;

`ifdef PARITY_CHECK_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, s_in, s_en, clr;
  logic [3:0] p_out_m, p_out_l;
  logic       p_valid_m, p_valid_l, busy_m, busy_l, perr_m, perr_l;
  logic [2:0] bit_cnt_m, bit_cnt_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] data;
    logic       flip;
    logic [3:0] exp_out;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] word;
    logic       err;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t e_m, e_l;

  sipo_4bit_shift_reg_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .clr(clr),
    .p_out(p_out_m), .p_valid(p_valid_m), .busy(busy_m),
    .bit_cnt(bit_cnt_m), .parity_err(perr_m)
  );

  sipo_4bit_shift_reg_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .clr(clr),
    .p_out(p_out_l), .p_valid(p_valid_l), .busy(busy_l),
    .bit_cnt(bit_cnt_l), .parity_err(perr_l)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

  // Scoreboard: every p_valid pulse must match the oldest pending word of that instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (p_valid_m) begin
        if (q_m.size() == 0) begin
          check_output("unexpected p_valid msb", 1, 0);
        end else begin
          e_m = q_m.pop_front();
          check_output("p_out msb", p_out_m, e_m.word);
          check_output("parity_err msb", perr_m, e_m.err);
        end
      end else begin
        check_output("parity_err idle msb", perr_m, 0);
      end
      if (p_valid_l) begin
        if (q_l.size() == 0) begin
          check_output("unexpected p_valid lsb", 1, 0);
        end else begin
          e_l = q_l.pop_front();
          check_output("p_out lsb", p_out_l, e_l.word);
          check_output("parity_err lsb", perr_l, e_l.err);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    s_en = 1'b1;
    s_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expect(input logic [3:0] word, input logic flip);
    exp_t e;
    e.word = word;
`ifdef PARITY_CHECK_EN
    e.err = flip;
`else
    e.err = 1'b0;
`endif
    q_m.push_back(e);
    e.word = rev4(word);
    q_l.push_back(e);
  endtask

  // Sends data[3] first; an optional gap of gap_len idle cycles follows bit index gap_pos.
  task automatic apply_stimulus(input logic [3:0] data, input logic flip, input int gap_pos, input int gap_len);
    push_expect(data, flip);
    for (int i = 3; i >= 0; i--) begin
      send_bit(data[i]);
      if (i == gap_pos) begin
        s_en = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk);
          #1;
          check_output("busy in gap", busy_m, 1);
          check_output("p_valid in gap", p_valid_m, 0);
          check_output("bit_cnt in gap", bit_cnt_m, 4 - i);
        end
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit((^data) ^ flip);
`endif
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{data: 4'b1011, flip: 1'b0, exp_out: 4'b1011, exp_err: 1'b0};
    vecs[1] = '{data: 4'b0110, flip: 1'b0, exp_out: 4'b0110, exp_err: 1'b0};
    vecs[2] = '{data: 4'b1001, flip: 1'b0, exp_out: 4'b1001, exp_err: 1'b0};
    vecs[3] = '{data: 4'b0000, flip: 1'b0, exp_out: 4'b0000, exp_err: 1'b0};

    rst  = 1'b1;
    s_in = 1'b0;
    s_en = 1'b0;
    clr  = 1'b0;
    #12;
    check_output("reset p_out", p_out_m, 0);
    check_output("reset p_valid", p_valid_m, 0);
    check_output("reset busy", busy_m, 0);
    check_output("reset bit_cnt", bit_cnt_m, 0);
    check_output("reset parity_err", perr_m, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word with per-edge count and strobe checks.
    push_expect(4'b1011, 1'b0);
    begin
      logic [FRAME-1:0] bits;
`ifdef PARITY_CHECK_EN
      bits = 5'b10111;
`else
      bits = 4'b1011;
`endif
      for (int k = 0; k < FRAME; k++) begin
        send_bit(bits[FRAME-1-k]);
        check_output("bit_cnt step", bit_cnt_m, (k + 1) % FRAME);
        check_output("p_valid step", p_valid_m, (k == FRAME - 1) ? 1 : 0);
      end
    end
    idle(1);
    check_output("p_valid one cycle", p_valid_m, 0);
    check_output("p_out held", p_out_m, 4'b1011);

    // Back-to-back words from the table with no idle gap.
    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].data, vecs[v].flip, -1, 0);
      check_output("p_valid at boundary", p_valid_m, 1);
      check_output("busy at boundary", busy_m, 0);
      check_output("p_out table", p_out_m, vecs[v].exp_out);
      check_output("parity_err table", perr_m, vecs[v].exp_err);
    end
    idle(2);

    // Words stretched by s_en gaps.
    apply_stimulus(4'b1111, 1'b0, 2, 2);
    idle(1);
    check_output("p_out after gap", p_out_m, 4'b1111);
    apply_stimulus(4'b1101, 1'b0, 2, 2);
    idle(1);
    check_output("p_out lsb-first gap", p_out_l, 4'b1011);

    // clr discards the partial word and the bit sampled alongside it.
    send_bit(1'b1);
    send_bit(1'b0);
    s_en = 1'b1;
    s_in = 1'b1;
    clr  = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_output("bit_cnt after clr", bit_cnt_m, 0);
    check_output("busy after clr", busy_m, 0);
    check_output("p_valid after clr", p_valid_m, 0);
    check_output("p_out held over clr", p_out_m, 4'b1101);
    apply_stimulus(4'b0110, 1'b0, -1, 0);
    check_output("p_out after clr word", p_out_m, 4'b0110);
    idle(1);

    // Asynchronous reset in the middle of a word.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    s_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("async rst p_out", p_out_m, 0);
    check_output("async rst bit_cnt", bit_cnt_m, 0);
    check_output("async rst busy", busy_m, 0);
    check_output("async rst p_valid", p_valid_m, 0);
    check_output("async rst parity_err", perr_m, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_expect(4'b1111, 1'b0);
    for (int k = 0; k < FRAME; k++) begin
      send_bit(1'b1);
      check_output("p_valid after rst", p_valid_m, (k == FRAME - 1) ? 1 : 0);
    end
    check_output("p_out after rst", p_out_m, 4'b1111);
    idle(1);

`ifdef PARITY_CHECK_EN
    // Good and corrupted parity bits.
    apply_stimulus(4'b1011, 1'b0, -1, 0);
    check_output("parity ok flag", perr_m, 0);
    check_output("parity ok p_out", p_out_m, 4'b1011);
    apply_stimulus(4'b1011, 1'b1, -1, 0);
    check_output("parity bad flag", perr_m, 1);
    check_output("parity bad p_out", p_out_m, 4'b1011);
    idle(1);
`endif

    idle(3);
    check_output("pending words msb", q_m.size(), 0);
    check_output("pending words lsb", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_4bit_shift_reg_rx.md
Name: sipo_4bit_shift_reg_rx

Overview:
Serial-in parallel-out receiver, the deserializing end of the 4-bit PISO serial link. Samples one serial bit per enabled clock edge and counts bits. After WIDTH bits, presents the assembled word on a parallel output and pulses a valid strobe for one cycle. Sits between the serial line from the PISO transmitter and parallel consumer logic. Supports back-to-back words with no idle gap.

Parameters:
WIDTH, 4, data word width in bits (>=2)
MSB_FIRST, 1, 1 = first received bit lands in p_out[WIDTH-1]; 0 = first received bit lands in p_out[0]

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
s_in  input  1  serial data bit
s_en  input  1  s_in is a valid bit this cycle; shift only when high
clr  input  1  synchronous frame restart; discards partial word
p_out  output  WIDTH  last completed word, held until next completion
p_valid  output  1  one-cycle pulse: p_out updated this cycle
busy  output  1  partial word in progress (bit count != 0)
bit_cnt  output  $clog2(WIDTH+1)  bits received in current frame
parity_err  output  1  parity error pulse (see Optional Feature; tied 0 when feature is off)

Behaviour:
- Interface fixed: one clock (clk); reset rst is asynchronous and active-high.
- rst high: shift reg, bit_cnt, p_out, p_valid, busy and parity_err go to 0 immediately, without waiting for a clock edge. Any partial word is lost.
- Internal shift reg sr[WIDTH-1:0]:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_in}.
  - MSB_FIRST=0: sr <= {s_in, sr[WIDTH-1:1]}.
- Each rising edge, in priority order: clr, then s_en, then hold.
- clr=1: bit_cnt <= 0 and sr <= 0. Any s_en bit in that cycle is discarded. p_out is unchanged. p_valid <= 0.
- s_en=1 and bit_cnt < FRAME-1, where FRAME = WIDTH, or WIDTH+1 with parity: shift s_in in and increment bit_cnt. p_valid <= 0.
- s_en=1 and bit_cnt == FRAME-1 (last bit):
  - p_out <= the assembled word, including this bit.
  - p_valid <= 1.
  - bit_cnt <= 0 (wrap).
  - sr is free to restart.
- s_en=0: sr, bit_cnt and p_out hold; p_valid <= 0.
- Latency: p_out and p_valid are valid right after the edge that samples the last bit. p_valid is high for exactly one cycle per word.
- Continuous s_en: p_valid pulses every FRAME cycles. No bit is dropped across the wrap.
- s_en gaps inside a word are allowed. They only stretch the word; busy stays high during the gaps.
- busy = (bit_cnt != 0), combinational from the registered count.
- All outputs are registered except busy.

Optional Feature:
Macro: PARITY_CHECK_EN
- Defined:
  - Frame = WIDTH data bits followed by one even-parity bit. The parity bit is not shifted into p_out.
  - On the parity-bit edge: p_out <= data, p_valid <= 1, and parity_err <= ^{data, parity_bit}.
  - parity_err is a one-cycle pulse, coincident with p_valid.
  - p_out updates even when parity_err is 1.
  - bit_cnt counts 0..WIDTH.
- Undefined:
  - Frame = WIDTH bits.
  - parity_err is constant 0.
  - No extra logic is generated.

Test Plan:
1. WIDTH=4, MSB_FIRST=1. Release rst, then s_en=1 with s_in=1,0,1,1 on successive edges -> after 4th edge p_out=1011 and p_valid=1 for one cycle. bit_cnt goes 1,2,3,0.
2. Continuous s_en, bits 1011 then 0110 with no gap -> p_valid high after edges 4 and 8 only; p_out=1011, then 0110. busy low only at the word boundaries.
3. s_en pattern 1,1 (s_in 1,1), 2 cycles s_en=0, then 1,1 (s_in 1,1) -> p_valid never high during the gap, busy=1 in the gap, final p_out=1111. Repeat with MSB_FIRST=0 and bits 1,1,0,1 -> p_out=1011.
4. After 2 bits of 1,0 assert clr (with s_en=1, s_in=1), then send 0,1,1,0 -> bit_cnt=0 after clr, the clr-cycle bit is ignored, p_valid fires exactly once, p_out=0110, and the previous p_out is held until then.
5. After 3 bits of 1111, assert rst asynchronously between edges -> all outputs 0 before the next edge. After release, send 1111 -> p_out=1111 and p_valid after exactly 4 enabled edges.
6. PARITY_CHECK_EN defined. Send 1011+parity 1 -> p_out=1011, p_valid=1, parity_err=0. Send 1011+parity 0 -> p_out=1011, p_valid=1, parity_err=1. Macro undefined -> parity_err stays 0 throughout tests 1-5.
